spi_bus_arb: RTL and testbench

Two-client arbiter and sequencer for the single SPI master (`SPI_mnrch`) on the board SPI bus. Each client posts a 16-bit command and waits for a 16-bit response. The arbiter grants the bus round-robin, launches the transaction, watches for completion with a watchdog, then returns the response to the owning client. It sits between the inertial interface (client 0), a second SPI peripheral controller (client 1) and the shared `SPI_mnrch`; external glue gates `SS_n` into per-chip selects using `owner`.

---
 rtl/spi_bus_arb.sv | 139 +++++++++++++
 tb/tb_spi_bus_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arb.sv
// Two-client round-robin arbiter and sequencer in front of the shared SPI master.
// Grants the bus, launches one transaction, guards it with a watchdog, and returns the response.
module spi_bus_arb #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] resp0,
    output logic [15:0] resp1,
    output logic        snd,
    output logic [15:0] cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_resp,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        BUSY    = 3'd2,
        REL_OK  = 3'd3,
        REL_ERR = 3'd4
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last;
    logic [15:0] wdog;
    logic        grant_vld;
    logic        grant_id;
    logic        wdog_expired;

    // With both clients pending, the one that did not own the bus last wins.
    always_comb begin
        grant_vld = req0 | req1;
        grant_id  = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    assign wdog_expired = (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // spi_done takes priority over the watchdog when both land on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = BUSY;
            end
            BUSY: begin
                if (spi_done) begin
                    state_nxt = REL_OK;
                end else if (wdog_expired) begin
                    state_nxt = REL_ERR;
                end
            end
            REL_OK:  state_nxt = IDLE;
            REL_ERR: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
            cmd   <= 16'h0000;
        end else if (state == IDLE && grant_vld) begin
            owner <= grant_id;
            cmd   <= grant_id ? cmd1 : cmd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= 16'h0000;
        end else if (state == LAUNCH) begin
            wdog <= 16'h0000;
        end else if (state == BUSY) begin
            wdog <= wdog + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (state == REL_OK || state == REL_ERR) begin
            last <= owner;
        end
    end

    // Responses are captured only for a completion seen in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0 <= 16'h0000;
            resp1 <= 16'h0000;
        end else if (state == BUSY && spi_done) begin
            if (owner) begin
                resp1 <= spi_resp;
            end else begin
                resp0 <= spi_resp;
            end
        end
    end

    assign snd   = (state == LAUNCH);
    assign busy  = (state != IDLE);
    assign done0 = (state == REL_OK)  && !owner;
    assign done1 = (state == REL_OK)  &&  owner;
    assign err0  = (state == REL_ERR) && !owner;
    assign err1  = (state == REL_ERR) &&  owner;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Directed bench for spi_bus_arb: a cycle vector table plus hand-written multi-cycle sequences.
module tb_spi_bus_arb;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] cmd0, cmd1;
    logic        done0, done1, err0, err1;
    logic [15:0] resp0, resp1;
    logic        snd;
    logic [15:0] cmd;
    logic        spi_done;
    logic [15:0] spi_resp;
    logic        owner;
    logic        busy;

    int checks = 0;
    int errors = 0;

    spi_bus_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .resp0(resp0), .resp1(resp1),
        .snd(snd), .cmd(cmd), .spi_done(spi_done), .spi_resp(spi_resp),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic        rst_n, r0, r1;
        logic [15:0] c0, c1;
        logic        sd;
        logic [15:0] sr;
        logic        snd, busy, own;
        logic [15:0] cmd;
        logic        d0, d1, e0, e1;
        logic [15:0] rs0, rs1;
    } vec_t;

    vec_t vt[18];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the launch strobe; an expired bound shows up as a failed check.
    task automatic wait_snd(input string nm);
        int n;
        n = 0;
        tick();
        while (!snd && n < 20) begin
            tick();
            n++;
        end
        chk1({nm, "_snd"}, snd, 1'b1);
    endtask

    logic [15:0] exp_r0, exp_r1;
    logic        exp_own;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        cmd0 = 16'h0000; cmd1 = 16'h0000;
        spi_done = 1'b0; spi_resp = 16'h0000;

        //            rst   r0    r1    c0       c1       sd    sr         snd   busy  own   cmd      d0    d1    e0    e1    rs0      rs1
        vt[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 16'hA400, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hA400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 16'hA400, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 16'hA400, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 16'hA400, 16'h0000, 1'b1, 16'h0037, 1'b0, 1'b1, 1'b0, 16'hA400, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0037, 16'h0000};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 16'hA400, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0037, 16'h0000};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 16'hA401, 16'h1053, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hA401, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[10] = '{1'b1, 1'b1, 1'b1, 16'hA401, 16'h1053, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA401, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vt[11] = '{1'b1, 1'b1, 1'b1, 16'hA401, 16'h1053, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'hA401, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vt[12] = '{1'b1, 1'b0, 1'b1, 16'hA401, 16'h1053, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA401, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vt[13] = '{1'b1, 1'b0, 1'b1, 16'hA401, 16'h1053, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1053, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vt[14] = '{1'b1, 1'b0, 1'b1, 16'hA401, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1053, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000};
        vt[15] = '{1'b1, 1'b0, 1'b1, 16'hA401, 16'hFFFF, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h1053, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vt[16] = '{1'b1, 1'b0, 1'b0, 16'hA401, 16'hFFFF, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h1053, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222};
        vt[17] = '{1'b1, 1'b0, 1'b0, 16'hA401, 16'hFFFF, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h1053, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_n = vt[i].rst_n; req0 = vt[i].r0; req1 = vt[i].r1;
            cmd0 = vt[i].c0; cmd1 = vt[i].c1;
            spi_done = vt[i].sd; spi_resp = vt[i].sr;
            @(posedge clk);
            #1;
            chk1 ($sformatf("v%0d_snd",   i), snd,   vt[i].snd);
            chk1 ($sformatf("v%0d_busy",  i), busy,  vt[i].busy);
            chk1 ($sformatf("v%0d_owner", i), owner, vt[i].own);
            chk16($sformatf("v%0d_cmd",   i), cmd,   vt[i].cmd);
            chk1 ($sformatf("v%0d_done0", i), done0, vt[i].d0);
            chk1 ($sformatf("v%0d_done1", i), done1, vt[i].d1);
            chk1 ($sformatf("v%0d_err0",  i), err0,  vt[i].e0);
            chk1 ($sformatf("v%0d_err1",  i), err1,  vt[i].e1);
            chk16($sformatf("v%0d_resp0", i), resp0, vt[i].rs0);
            chk16($sformatf("v%0d_resp1", i), resp1, vt[i].rs1);
        end
        spi_done = 1'b0;
        exp_r0 = 16'h1111;
        exp_r1 = 16'h2222;

        // Round robin: both requests held for six transactions, client 1 owned the bus last.
        req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h0C00; cmd1 = 16'h1C00;
        for (int t = 0; t < 6; t++) begin
            exp_own = t[0];
            wait_snd($sformatf("rr%0d", t));
            chk1 ($sformatf("rr%0d_owner", t), owner, exp_own);
            chk16($sformatf("rr%0d_cmd", t), cmd, exp_own ? 16'h1C00 : 16'h0C00);
            tick();
            chk1 ($sformatf("rr%0d_snd_one", t), snd, 1'b0);
            tick();
            spi_done = 1'b1; spi_resp = 16'h5000 + 16'(t);
            tick();
            spi_done = 1'b0;
            if (exp_own) exp_r1 = 16'h5000 + 16'(t);
            else         exp_r0 = 16'h5000 + 16'(t);
            chk1 ($sformatf("rr%0d_done0", t), done0, !exp_own);
            chk1 ($sformatf("rr%0d_done1", t), done1, exp_own);
            chk16($sformatf("rr%0d_resp0", t), resp0, exp_r0);
            chk16($sformatf("rr%0d_resp1", t), resp1, exp_r1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Watchdog abort on client 1, then client 0 is still served.
        req1 = 1'b1; cmd1 = 16'h1234;
        wait_snd("to");
        chk1 ("to_owner", owner, 1'b1);
        chk16("to_cmd", cmd, 16'h1234);
        for (int k = 1; k <= TO + 1; k++) begin
            tick();
            if (k <= TO) begin
                chk1($sformatf("to_noerr_%0d", k), err1, 1'b0);
                chk1($sformatf("to_busy_%0d", k), busy, 1'b1);
            end else begin
                chk1 ("to_err1", err1, 1'b1);
                chk1 ("to_done1", done1, 1'b0);
                chk16("to_resp1_kept", resp1, exp_r1);
            end
        end
        req1 = 1'b0; req0 = 1'b1; cmd0 = 16'h0AAA;
        wait_snd("after_to");
        chk1 ("after_to_owner", owner, 1'b0);
        chk16("after_to_cmd", cmd, 16'h0AAA);
        tick(); tick();
        spi_done = 1'b1; spi_resp = 16'h0A0A;
        tick();
        spi_done = 1'b0;
        chk1 ("after_to_done0", done0, 1'b1);
        chk16("after_to_resp0", resp0, 16'h0A0A);
        req0 = 1'b0;
        tick();

        // spi_done on the watchdog terminal count completes normally.
        req0 = 1'b1; cmd0 = 16'h0BBB;
        wait_snd("tc");
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk1($sformatf("tc_noerr_%0d", k), err0, 1'b0);
        end
        spi_done = 1'b1; spi_resp = 16'h0C0C;
        tick();
        spi_done = 1'b0;
        chk1 ("tc_done0", done0, 1'b1);
        chk1 ("tc_err0", err0, 1'b0);
        chk16("tc_resp0", resp0, 16'h0C0C);
        req0 = 1'b0;
        tick();

        // Asynchronous reset while BUSY.
        req1 = 1'b1; cmd1 = 16'h0DDD;
        wait_snd("rst");
        tick(); tick();
        chk1("rst_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_snd", snd, 1'b0);
        chk1 ("rst_owner", owner, 1'b0);
        chk16("rst_cmd", cmd, 16'h0000);
        chk16("rst_resp0", resp0, 16'h0000);
        chk16("rst_resp1", resp1, 16'h0000);
        req1 = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1($sformatf("rst_idle_busy_%0d", k), busy, 1'b0);
            chk1($sformatf("rst_idle_pulse_%0d", k), done0 | done1 | err0 | err1, 1'b0);
        end
        req0 = 1'b1; req1 = 1'b1;
        wait_snd("rst_rr");
        chk1("rst_rr_owner", owner, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
